// File: rtl/ov7670_capture_ctrl.sv
// OV7670 capture controller: syncs the camera bus, pairs bytes into RGB565,
// decimates, and writes whole frames into a rotating set of buffer banks.
module ov7670_capture_ctrl #(
    parameter int H_ACT   = 320,
    parameter int V_ACT   = 240,
    parameter int DECIM   = 1,
    parameter int NUM_BUF = 2,
    parameter int ADDR_W  = 17,
    localparam int BW     = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cam_pclk,
    input  logic              cam_href,
    input  logic              cam_vsync,
    input  logic [7:0]        cam_data,
    input  logic [1:0]        mode,
    input  logic              snap_req,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [15:0]       wData,
    output logic [BW-1:0]     wr_bank,
    output logic [BW-1:0]     rd_bank,
    output logic              frame_done,
    output logic              err_short,
    output logic              busy
);

    localparam int CW        = $clog2(H_ACT + 1);
    localparam int RW        = $clog2(V_ACT + 1);
    localparam int FRAME_PIX = (H_ACT / DECIM) * (V_ACT / DECIM);
    localparam int NW        = ADDR_W + 1;

    typedef enum logic {
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t state;

    logic [1:0]    pclk_sr, href_sr, vs_sr;
    logic [7:0]    d_s1, d_s2;
    logic          pclk_q, href_q, vs_q;
    logic          toggle;
    logic [7:0]    hi_byte;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [NW-1:0] pix_cnt;
    logic          armed;

    logic              byte_stb, pix_stb, href_fall, vs_fall, vs_rise, kept;
    logic [ADDR_W-1:0] addr_calc;

    // Edge detection on the synchronised camera strobes
    always_comb begin
        byte_stb  = pclk_sr[1] & ~pclk_q & href_sr[1];
        href_fall = href_q & ~href_sr[1];
        vs_fall   = vs_q & ~vs_sr[1];
        vs_rise   = ~vs_q & vs_sr[1];
        pix_stb   = byte_stb & toggle & ~vs_fall;
        kept      = (int'(col) < H_ACT) && (int'(row) < V_ACT) &&
                    ((int'(col) % DECIM) == 0) &&
                    ((int'(row) % DECIM) == 0);
        addr_calc = ADDR_W'((int'(row) / DECIM) * (H_ACT / DECIM) +
                            int'(col) / DECIM);
    end

    // Two-flop synchronisers plus one history flop for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pclk_sr <= '0;
            href_sr <= '0;
            vs_sr   <= '0;
            d_s1    <= '0;
            d_s2    <= '0;
            pclk_q  <= 1'b0;
            href_q  <= 1'b0;
            vs_q    <= 1'b0;
        end else begin
            pclk_sr <= {pclk_sr[0], cam_pclk};
            href_sr <= {href_sr[0], cam_href};
            vs_sr   <= {vs_sr[0], cam_vsync};
            d_s1    <= cam_data;
            d_s2    <= d_s1;
            pclk_q  <= pclk_sr[1];
            href_q  <= href_sr[1];
            vs_q    <= vs_sr[1];
        end
    end

    // Byte pairing and saturating column/row counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            toggle  <= 1'b0;
            hi_byte <= '0;
            col     <= '0;
            row     <= '0;
        end else if (vs_fall) begin
            toggle <= 1'b0;
            col    <= '0;
            row    <= '0;
        end else if (href_fall) begin
            toggle <= 1'b0;
            col    <= '0;
            if (col != '0 && int'(row) != V_ACT)
                row <= row + 1'b1;
        end else if (byte_stb) begin
            if (!toggle) begin
                hi_byte <= d_s2;
                toggle  <= 1'b1;
            end else begin
                toggle <= 1'b0;
                if (int'(col) != H_ACT)
                    col <= col + 1'b1;
            end
        end
    end

    // Capture FSM with registered write port, bank rotation and status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_WAIT;
            armed      <= 1'b0;
            pix_cnt    <= '0;
            we         <= 1'b0;
            wAddr      <= '0;
            wData      <= '0;
            wr_bank    <= '0;
            rd_bank    <= '0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            we         <= 1'b0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            unique case (state)
                S_WAIT: begin
                    if (snap_req && mode == 2'b10)
                        armed <= 1'b1;
                    if (vs_fall && mode != 2'b01 &&
                        (mode != 2'b10 || armed)) begin
                        state   <= S_CAPTURE;
                        busy    <= 1'b1;
                        pix_cnt <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (mode == 2'b01) begin
                        state <= S_WAIT;
                        busy  <= 1'b0;
                    end else if (vs_rise) begin
                        if (pix_cnt == NW'(FRAME_PIX)) begin
                            frame_done <= 1'b1;
                            rd_bank    <= wr_bank;
                            wr_bank    <= (wr_bank == BW'(NUM_BUF - 1)) ?
                                          '0 : wr_bank + 1'b1;
                            armed      <= 1'b0;
                        end else begin
                            err_short <= 1'b1;
                        end
                        state <= S_WAIT;
                        busy  <= 1'b0;
                    end else if (pix_stb && kept) begin
                        we      <= 1'b1;
                        wAddr   <= addr_calc;
                        wData   <= {hi_byte, d_s2};
                        pix_cnt <= pix_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Directed bench for ov7670_capture_ctrl: an 8x4 camera model drives two
// instances (DECIM=1 and DECIM=2) and a monitor records every write.
module tb_ov7670_capture_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cam_pclk = 1'b0;
    logic       cam_href = 1'b0;
    logic       cam_vsync = 1'b1;
    logic [7:0] cam_data = '0;
    logic [1:0] mode = 2'b00;
    logic       snap_req = 1'b0;

    logic        a_we, a_fd, a_es, a_busy;
    logic [16:0] a_addr;
    logic [15:0] a_data;
    logic [0:0]  a_wrb, a_rdb;
    logic        b_we, b_fd, b_es, b_busy;
    logic [16:0] b_addr;
    logic [15:0] b_data;
    logic [0:0]  b_wrb, b_rdb;

    int n_assert = 0;
    int n_fail   = 0;

    logic [16:0] qa_addr[$];
    logic [15:0] qa_data[$];
    logic [0:0]  qa_bank[$];
    logic [16:0] qb_addr[$];
    logic [15:0] qb_data[$];
    int na_fd = 0, na_es = 0, nb_fd = 0;

    always #5 clk = ~clk;

    ov7670_capture_ctrl #(
        .H_ACT(8), .V_ACT(4), .DECIM(1), .NUM_BUF(2), .ADDR_W(17)
    ) dut_a (
        .clk(clk), .reset(reset), .cam_pclk(cam_pclk),
        .cam_href(cam_href), .cam_vsync(cam_vsync),
        .cam_data(cam_data), .mode(mode), .snap_req(snap_req),
        .we(a_we), .wAddr(a_addr), .wData(a_data),
        .wr_bank(a_wrb), .rd_bank(a_rdb), .frame_done(a_fd),
        .err_short(a_es), .busy(a_busy)
    );

    ov7670_capture_ctrl #(
        .H_ACT(8), .V_ACT(4), .DECIM(2), .NUM_BUF(2), .ADDR_W(17)
    ) dut_b (
        .clk(clk), .reset(reset), .cam_pclk(cam_pclk),
        .cam_href(cam_href), .cam_vsync(cam_vsync),
        .cam_data(cam_data), .mode(mode), .snap_req(snap_req),
        .we(b_we), .wAddr(b_addr), .wData(b_data),
        .wr_bank(b_wrb), .rd_bank(b_rdb), .frame_done(b_fd),
        .err_short(b_es), .busy(b_busy)
    );

    // Write/pulse recorder, sampled on the falling edge
    always @(negedge clk) begin
        if (a_we) begin
            qa_addr.push_back(a_addr);
            qa_data.push_back(a_data);
            qa_bank.push_back(a_wrb);
        end
        if (a_fd) na_fd++;
        if (a_es) na_es++;
        if (b_we) begin
            qb_addr.push_back(b_addr);
            qb_data.push_back(b_data);
        end
        if (b_fd) nb_fd++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        qa_addr.delete();
        qa_data.delete();
        qa_bank.delete();
        qb_addr.delete();
        qb_data.delete();
        na_fd = 0;
        na_es = 0;
        nb_fd = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam_data = b;
        cam_pclk = 1'b0;
        repeat (4) @(posedge clk);
        cam_pclk = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_bytes(input int n, input int base);
        for (int i = 0; i < n; i++)
            send_byte(8'(base + i));
    endtask

    task automatic line_end();
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic send_line(input int n, input int base);
        cam_href = 1'b1;
        repeat (4) @(posedge clk);
        send_bytes(n, base);
        line_end();
    endtask

    task automatic frame_start();
        cam_vsync = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic frame_end();
        cam_vsync = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic full_frame();
        frame_start();
        for (int l = 0; l < 4; l++)
            send_line(16, l * 16);
        frame_end();
    endtask

    initial begin
        logic [15:0] exp_d;
        int          k;

        // Reset state
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", {28'd0, a_we, a_fd, a_es, a_busy}, 32'd0);
        chk("rst_addr", 32'(a_addr), 32'd0);
        chk("rst_data", 32'(a_data), 32'd0);
        chk("rst_banks", {30'd0, a_wrb, a_rdb}, 32'd0);
        reset = 1'b0;
        repeat (5) @(posedge clk);

        // Full frame, continuous mode, bytes 0x00..0x3F
        clr();
        full_frame();
        chk("t1_nwr", qa_addr.size(), 32);
        for (int i = 0; i < 32; i++) begin
            exp_d = {8'(2 * i), 8'(2 * i + 1)};
            chk($sformatf("t1_addr%0d", i), 32'(qa_addr[i]), i);
            chk($sformatf("t1_data%0d", i), 32'(qa_data[i]), 32'(exp_d));
        end
        chk("t1_fd", na_fd, 1);
        chk("t1_es", na_es, 0);
        chk("t1_rd", 32'(a_rdb), 0);
        chk("t1_wr", 32'(a_wrb), 1);
        chk("t1_busy", 32'(a_busy), 0);

        // Same frame seen through the DECIM=2 instance
        chk("t2_nwr", qb_addr.size(), 8);
        for (int j = 0; j < 8; j++) begin
            k = ((j / 4) * 2) * 8 + (j % 4) * 2;
            exp_d = {8'(2 * k), 8'(2 * k + 1)};
            chk($sformatf("t2_addr%0d", j), 32'(qb_addr[j]), j);
            chk($sformatf("t2_data%0d", j), 32'(qb_data[j]), 32'(exp_d));
        end
        chk("t2_fd", nb_fd, 1);

        // Odd-length first line: dangling byte dropped, frame short
        clr();
        frame_start();
        send_line(15, 0);
        for (int l = 1; l < 4; l++)
            send_line(16, l * 16);
        frame_end();
        chk("t3_nwr", qa_addr.size(), 31);
        chk("t3_l0last_a", 32'(qa_addr[6]), 6);
        chk("t3_l0last_d", 32'(qa_data[6]), 32'h0C0D);
        chk("t3_l1first_a", 32'(qa_addr[7]), 8);
        chk("t3_l1first_d", 32'(qa_data[7]), 32'h1011);
        chk("t3_es", na_es, 1);
        chk("t3_fd", na_fd, 0);
        chk("t3_banks", {30'd0, a_wrb, a_rdb}, 32'b10);

        // Single-shot: request arrives mid-frame
        clr();
        mode = 2'b10;
        frame_start();
        send_line(16, 0);
        send_line(16, 16);
        @(negedge clk);
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        send_line(16, 32);
        send_line(16, 48);
        frame_end();
        chk("t4_nwr_pre", qa_addr.size(), 0);
        chk("t4_busy_pre", 32'(a_busy), 0);
        full_frame();
        chk("t4_nwr", qa_addr.size(), 32);
        chk("t4_bank_wr", 32'(qa_bank[0]), 1);
        chk("t4_lastaddr", 32'(qa_addr[31]), 31);
        chk("t4_fd", na_fd, 1);
        chk("t4_banks", {30'd0, a_wrb, a_rdb}, 32'b01);
        clr();
        full_frame();
        chk("t4_nwr_post", qa_addr.size(), 0);
        chk("t4_fd_post", na_fd, 0);
        mode = 2'b00;

        // Freeze asserted after pixel 10 of a capture
        clr();
        frame_start();
        send_line(16, 0);
        cam_href = 1'b1;
        repeat (4) @(posedge clk);
        send_bytes(4, 16);
        repeat (6) @(posedge clk);
        mode = 2'b01;
        send_bytes(12, 20);
        line_end();
        send_line(16, 32);
        send_line(16, 48);
        frame_end();
        chk("t5_nwr", qa_addr.size(), 10);
        chk("t5_last", 32'(qa_addr[9]), 9);
        chk("t5_fd", na_fd, 0);
        chk("t5_es", na_es, 0);
        chk("t5_banks", {30'd0, a_wrb, a_rdb}, 32'b01);
        chk("t5_busy", 32'(a_busy), 0);
        mode = 2'b00;

        // Reset pulsed after pixel 20
        clr();
        frame_start();
        send_line(16, 0);
        send_line(16, 16);
        cam_href = 1'b1;
        repeat (4) @(posedge clk);
        send_bytes(8, 32);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("t6_nwr_pre", qa_addr.size(), 20);
        chk("t6_busy_pre", 32'(a_busy), 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_ctl", {28'd0, a_we, a_fd, a_es, a_busy}, 32'd0);
        chk("t6_rst_addr", 32'(a_addr), 32'd0);
        chk("t6_rst_data", 32'(a_data), 32'd0);
        chk("t6_rst_banks", {30'd0, a_wrb, a_rdb}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        clr();
        send_bytes(8, 40);
        line_end();
        frame_end();
        chk("t6_nwr_mid", qa_addr.size(), 0);
        full_frame();
        chk("t6_nwr", qa_addr.size(), 32);
        chk("t6_first", 32'(qa_addr[0]), 0);
        chk("t6_first_d", 32'(qa_data[0]), 32'h0001);
        chk("t6_bank", 32'(qa_bank[0]), 0);
        chk("t6_fd", na_fd, 1);
        chk("t6_banks", {30'd0, a_wrb, a_rdb}, 32'b10);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
